// File: rtl/mips_sys_pkg.sv
// Shared definitions for the syscall responder: service codes, FSM states, ASCII constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_sys_pkg;

   localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
   localparam logic [31:0] SYS_EXIT2      = 32'd17;
   localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A_LC  = 8'h61;
   localparam logic [7:0] ASCII_MINUS = 8'h2d;

   typedef enum logic [2:0] {IDLE, CONVERT, EMIT, SKIP, HALTED} state_t;

   typedef enum logic [1:0] {MODE_CHAR, MODE_HEX, MODE_INT} emit_mode_t;

   // One double-dabble iteration on {bcd[39:0], bin[31:0]}: correct every
   // digit that would overflow on doubling, then shift the whole word left.
   function automatic logic [71:0] dd_step(input logic [71:0] v);
      logic [71:0] t;
      t = v;
      for (int d = 0; d < 10; d++) begin
         if (t[32 + 4*d +: 4] >= 4'd5)
            t[32 + 4*d +: 4] = t[32 + 4*d +: 4] + 4'd3;
      end
      return {t[70:0], 1'b0};
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return ASCII_0 + {4'b0000, nib};
      else
         return ASCII_A_LC + {4'b0000, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/syscall_unit_if.sv
// Bundle between the core's MEM stage / console sink and the syscall responder.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready handshake on the console byte stream; sys_busy freezes the core.
// Ports: sys_req/sys_v0/sys_a0 request, sys_busy, out_valid/out_data/out_ready, halt/exit_code.
interface syscall_unit_if #(parameter int DATA_W = 32);

   logic              sys_req;
   logic [DATA_W-1:0] sys_v0;
   logic [DATA_W-1:0] sys_a0;
   logic              sys_busy;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_ready;
   logic              halt;
   logic [7:0]        exit_code;

   // Core / environment side.
   modport master (
      output sys_req, sys_v0, sys_a0, out_ready,
      input  sys_busy, out_valid, out_data, halt, exit_code
   );

   // Responder side.
   modport slave (
      input  sys_req, sys_v0, sys_a0, out_ready,
      output sys_busy, out_valid, out_data, halt, exit_code
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 10-digit BCD converter (double-dabble, one bit per cycle).
// Latency: first shift on the start edge, result valid with done 32 cycles after start.
// Backpressure: none; result holds until the next start.
// Ports: clk, rst, start, bin[31:0] in; busy, done (one-cycle pulse), bcd[39:0] out.
module bin2bcd_seq
   import mips_sys_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        busy,
   output logic        done,
   output logic [39:0] bcd
);

   logic [71:0] sh;
   logic [4:0]  cnt;

   // The start edge already performs the first of the 32 shifts so that the
   // final digits are present in the cycle where done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sh   <= dd_step({40'd0, bin});
            cnt  <= 5'd31;
            busy <= 1'b1;
         end else if (busy) begin
            sh  <= dd_step(sh);
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign bcd = sh[71:32];

endmodule

// File: rtl/syscall_unit.sv
// Syscall responder: serves print int/char/hex as an ASCII byte stream, exit services raise a sticky halt.
// Latency: char/hex first byte C0+1, int first byte C0+33, exit halt at C0+1, unknown code busy one cycle.
// Backpressure: out_ready low stalls EMIT indefinitely with out_data held; sys_busy stays high meanwhile.
// Ports: clk, rst (sync, active high), bus (syscall_unit_if.slave).
module syscall_unit
   import mips_sys_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input logic           clk,
   input logic           rst,
   syscall_unit_if.slave bus
);

   state_t            state, state_nxt;
   emit_mode_t        mode;
   logic [DATA_W-1:0] a0_q;
   logic              sign_pend;
   logic [3:0]        idx;
   logic [7:0]        exit_q;

   logic              bcd_start, bcd_busy, bcd_done;
   logic [39:0]       bcd;
   logic [31:0]       mag;
   logic [3:0]        lead;
   logic              hs, last_byte;

   // Magnitude as an unsigned value: 0x80000000 negates to itself.
   assign mag       = bus.sys_a0[DATA_W-1] ? (~bus.sys_a0 + 32'd1) : bus.sys_a0;
   assign bcd_start = (state == IDLE) && bus.sys_req && (bus.sys_v0 == SYS_PRINT_INT);
   assign hs        = (state == EMIT) && bus.out_ready;

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (bcd_start),
      .bin   (mag),
      .busy  (bcd_busy),
      .done  (bcd_done),
      .bcd   (bcd)
   );

   // Index of the most significant non-zero digit; 0 when the value is 0.
   always_comb begin
      lead = 4'd0;
      for (int d = 0; d < 10; d++) begin
         if (bcd[4*d +: 4] != 4'd0)
            lead = 4'(d);
      end
   end

   always_comb begin
      last_byte = 1'b1;
      case (mode)
         MODE_HEX: last_byte = (idx == 4'd0);
         MODE_INT: last_byte = !sign_pend && (idx == 4'd0);
         default:  last_byte = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic. Requests outside IDLE are ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.sys_req) begin
               case (bus.sys_v0)
                  SYS_PRINT_INT:                 state_nxt = CONVERT;
                  SYS_PRINT_CHAR, SYS_PRINT_HEX: state_nxt = EMIT;
                  SYS_EXIT, SYS_EXIT2:           state_nxt = HALTED;
                  default:                       state_nxt = SKIP;
               endcase
            end
         end
         CONVERT: begin
            if (bcd_done)
               state_nxt = EMIT;
            else if (!bcd_busy)
               state_nxt = IDLE;   // converter not running: nothing to wait for
         end
         EMIT:    if (hs && last_byte) state_nxt = IDLE;
         SKIP:    state_nxt = IDLE;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = IDLE;
      endcase
   end

   // Byte sequencing: operand latch, sign flag, digit / nibble index.
   always_ff @(posedge clk) begin
      if (rst) begin
         a0_q      <= '0;
         mode      <= MODE_CHAR;
         sign_pend <= 1'b0;
         idx       <= 4'd0;
         exit_q    <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.sys_req) begin
                  a0_q <= bus.sys_a0;
                  case (bus.sys_v0)
                     SYS_PRINT_INT: begin
                        mode      <= MODE_INT;
                        sign_pend <= bus.sys_a0[DATA_W-1];
                     end
                     SYS_PRINT_CHAR: mode <= MODE_CHAR;
                     SYS_PRINT_HEX: begin
                        mode <= MODE_HEX;
                        idx  <= 4'd7;
                     end
                     SYS_EXIT:  exit_q <= 8'd0;
                     SYS_EXIT2: exit_q <= bus.sys_a0[7:0];
                     default: ;
                  endcase
               end
            end
            CONVERT: if (bcd_done) idx <= lead;
            EMIT: begin
               if (hs) begin
                  if (sign_pend)
                     sign_pend <= 1'b0;
                  else if (idx != 4'd0)
                     idx <= idx - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs, decoded from registered state only.
   always_comb begin
      bus.sys_busy  = (state != IDLE);
      bus.out_valid = (state == EMIT);
      bus.halt      = (state == HALTED);
      bus.exit_code = exit_q;
      bus.out_data  = 8'd0;
      if (state == EMIT) begin
         case (mode)
            MODE_HEX: bus.out_data = hex_ascii(a0_q[{idx[2:0], 2'b00} +: 4]);
            MODE_INT: bus.out_data = sign_pend ? ASCII_MINUS
                                               : ASCII_0 + {4'b0000, bcd[{idx, 2'b00} +: 4]};
            default:  bus.out_data = a0_q[7:0];
         endcase
      end
   end

endmodule
